// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode constants, NOP encoding and fetch FSM state type.
package riscv_pkg;
    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I       = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_SB      = 7'b1100011;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_UJ_JAL  = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD
    } fetch_state_t;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with async reset, +4 increment and word-aligned redirect load.
// Ports: clk, rst (async, active-high), en (increment), load (redirect), load_pc (target), pc (current).
module pc_register #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);
    // load wins over increment; low two bits of the target are forced to zero
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= load_pc & ~XLEN'(3);
        else if (en) pc <= pc + XLEN'(4);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, one-outstanding imem request handshake and instruction register.
// Ports: clk, rst (async, active-high); imem_req_valid/ready/addr request channel;
// imem_rsp_valid/data response channel; redirect_valid/redirect_pc; stall;
// instr_valid, instr, instr_pc, opcode towards decode.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode
);
    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc;
    logic            capture;

    // a redirect in the response cycle discards the word
    assign capture = state == WAIT && imem_rsp_valid && !redirect_valid;

    pc_register #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .rst     (rst),
        .en      (capture),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // a request accepted alongside a redirect still owes a response, hence DRAIN
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = REQ;
            REQ:     state_next = imem_req_ready ? (redirect_valid ? DRAIN : WAIT) : REQ;
            WAIT:    state_next = imem_rsp_valid ? (redirect_valid ? REQ : HOLD)
                                                 : (redirect_valid ? DRAIN : WAIT);
            HOLD:    state_next = (redirect_valid || !stall) ? REQ : HOLD;
            DRAIN:   state_next = imem_rsp_valid ? REQ : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
        end else begin
            state       <= state_next;
            instr_valid <= state_next == HOLD;
            if (capture) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
        end

    assign imem_req_valid = state == REQ;
    assign imem_addr      = pc;
    assign opcode         = instr[6:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with a behavioural imem.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        redirect_valid, stall;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic [6:0]  opcode;

    logic        req_valid2, rsp_valid2, instr_valid2;
    logic [31:0] addr2, instr2, instr_pc2;
    logic [6:0]  opcode2;

    int checks = 0;
    int errors = 0;
    int lat = 1;
    logic [31:0] exp_req[$];
    logic [63:0] exp_ins[$];
    logic        held = 1'b0;
    logic [31:0] a2[2];
    int          n2 = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
    );

    instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_addr(addr2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(32'h0000_0013),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .stall(1'b0),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2), .opcode(opcode2)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h0 ? 32'h0000_0093 : a == 32'h4 ? 32'h0010_0113 : {a[24:0], 7'b0110011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int i;
        i = 0;
        @(negedge clk);
        while (!(imem_req_valid && imem_req_ready && imem_addr == a) && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("wait_req_timeout", {31'b0, i >= 40}, 32'h0);
    endtask

    task automatic wait_hold(input logic [31:0] p);
        int i;
        i = 0;
        @(negedge clk);
        while (!(instr_valid && instr_pc == p) && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("wait_hold_timeout", {31'b0, i >= 40}, 32'h0);
    endtask

    // memory model: one response per accepted request, lat cycles later
    initial begin
        logic [31:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && !rst) begin
                a = imem_addr;
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem(a);
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        logic h;
        rsp_valid2 = 1'b0;
        forever begin
            @(negedge clk);
            h = req_valid2;
            @(posedge clk);
            #1;
            rsp_valid2 = h;
        end
    end

    initial forever begin
        @(negedge clk);
        if (req_valid2 && n2 < 2) begin
            a2[n2] = addr2;
            n2++;
        end
    end

    // scoreboard monitor: pops one expectation per handshake and per newly presented instruction
    initial forever begin
        logic [31:0] e;
        logic [63:0] w;
        @(negedge clk);
        if (rst) held = 1'b0;
        else begin
            if (imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got %h expected none", imem_addr);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_addr", imem_addr, e);
                end
            end
            if (instr_valid && !held) begin
                if (exp_ins.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
                end else begin
                    w = exp_ins.pop_front();
                    chk("instr_pc", instr_pc, w[63:32]);
                    chk("instr", instr, w[31:0]);
                    chk("opcode", {25'b0, opcode}, {25'b0, w[6:0]});
                end
            end
            held = instr_valid && stall && !redirect_valid;
        end
    end

    initial begin
        logic [31:0] iw, ip;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h40, 32'h44, 32'h0};
        exp_ins = '{{32'h0, 32'h0000_0093}, {32'h4, 32'h0010_0113}, {32'h8, mem(32'h8)},
                    {32'hC, mem(32'hC)}, {32'h40, mem(32'h40)}, {32'h0, 32'h0000_0093}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_opcode", {25'b0, opcode}, 32'h13);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req", {31'b0, imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'h1);

        // stall in HOLD of pc 8
        wait_hold(32'h4);
        tick;
        stall = 1'b1;
        wait_hold(32'h8);
        iw = instr;
        ip = instr_pc;
        repeat (5) begin
            tick;
            @(negedge clk);
            chk("stall_instr", instr, iw);
            chk("stall_pc", instr_pc, ip);
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_no_req", {31'b0, imem_req_valid}, 32'h0);
        end
        tick;
        stall = 1'b0;

        // redirect in WAIT, response two cycles later
        wait_hold(32'hC);
        lat = 3;
        wait_req(32'h10);
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick;
        redirect_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("redir_addr", imem_addr, 32'h100);
        chk("drain_no_req", {31'b0, imem_req_valid}, 32'h0);

        // redirect coinciding with the response, then ready held low
        wait_req(32'h100);
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        imem_req_ready = 1'b0;
        tick;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("notready_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("notready_addr", imem_addr, 32'h40);
        tick;
        @(negedge clk);
        chk("notready_addr_stable", imem_addr, 32'h40);
        tick;
        imem_req_ready = 1'b1;
        wait_hold(32'h40);

        // reset during WAIT; stale response lands while reset is held
        lat = 3;
        wait_req(32'h44);
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("midrst_instr", instr, 32'h0000_0013);
        chk("midrst_instr_pc", instr_pc, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        repeat (4) tick;
        lat = 1;
        stall = 1'b1;
        rst = 1'b0;
        wait_hold(32'h0);
        repeat (3) tick;
        @(negedge clk);
        chk("req_queue_left", exp_req.size(), 32'h0);
        chk("ins_queue_left", exp_ins.size(), 32'h0);
        chk("wrap_count", n2, 32'h2);
        chk("wrap_first", a2[0], 32'hFFFF_FFFC);
        chk("wrap_second", a2[1], 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
